// File: rtl/msg_ram_streamer.sv
// Message RAM with a reset-loaded image and an autonomous streamer that
// plays entries out to a UART transmitter over a valid/ready handshake.
//
// Ports:
//   Clock, Reset        rising-edge clock, async active-high reset
//   Address, Din,       user read/write port; Dout is a combinational
//   WriteEnabled, Dout  read, and writes are refused while Busy
//   Start, Abort        begin / cut short a stream
//   TxData, TxValid,    registered character handshake toward the UART
//   TxReady
//   Busy, Done,         streamer status; Done pulses once per stream and
//   Aborted             Aborted qualifies it
//   WriteRejected       one-cycle pulse for a write attempted while Busy
//   CharsSent           characters accepted in the last/current stream
module msg_ram_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR = '0,
  parameter logic [DEPTH*DATA_WIDTH-1:0] INIT_MSG =
    {"Hello\r\n", {(DEPTH*DATA_WIDTH-56){1'b0}}}
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] Din,
  input  logic                  WriteEnabled,
  output logic [DATA_WIDTH-1:0] Dout,
  input  logic                  Start,
  input  logic                  Abort,
  output logic [DATA_WIDTH-1:0] TxData,
  output logic                  TxValid,
  input  logic                  TxReady,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Aborted,
  output logic                  WriteRejected,
  output logic [ADDR_WIDTH:0]   CharsSent
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR =
    ADDR_WIDTH'(DEPTH-1);

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   chars_q, chars_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  aborted_q, aborted_d;
  logic                  wr_rej_q, wr_rej_d;

  logic                  busy;
  logic                  addr_ok;
  logic                  wr_en;
  logic                  last_ptr;
  logic                  fetch_term;
  logic [DATA_WIDTH-1:0] fetch_word;

  assign busy       = (state_q != S_IDLE);
  assign addr_ok    = ({1'b0, Address} < DEPTH_W);
  assign wr_en      = WriteEnabled && !busy && addr_ok;
  assign last_ptr   = (ptr_q == LAST_PTR);
  assign fetch_word = mem_q[ptr_q];
  assign fetch_term = (fetch_word == TERMINATOR);

  // Memory: reset reloads the whole image, so string index 0
  // sits in the most significant slice of INIT_MSG.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <=
          INIT_MSG[(DEPTH-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (wr_en) begin
      mem_q[Address] <= Din;
    end
  end

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (Abort || fetch_term) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (Abort) begin
          state_d = S_DONE;
        end else if (TxReady) begin
          state_d = last_ptr ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr_q      <= '0;
      chars_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      aborted_q  <= 1'b0;
      wr_rej_q   <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      chars_q    <= chars_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      aborted_q  <= aborted_d;
      wr_rej_q   <= wr_rej_d;
    end
  end

  // Output / datapath logic
  always_comb begin
    ptr_d      = ptr_q;
    chars_d    = chars_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    aborted_d  = aborted_q;
    wr_rej_d   = WriteEnabled && busy;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          ptr_d     = '0;
          chars_d   = '0;
          aborted_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (Abort) begin
          tx_valid_d = 1'b0;
          aborted_d  = 1'b1;
        end else if (!fetch_term) begin
          tx_data_d  = fetch_word;
          tx_valid_d = 1'b1;
        end
      end
      S_SEND: begin
        // A handshake on the abort edge still counts.
        if (TxReady) begin
          tx_valid_d = 1'b0;
          chars_d    = chars_q + 1'b1;
          if (!last_ptr) begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        if (Abort) begin
          tx_valid_d = 1'b0;
          aborted_d  = 1'b1;
        end
      end
      S_DONE: begin
      end
      default: begin
      end
    endcase
  end

  assign Dout          = addr_ok ? mem_q[Address] : '0;
  assign TxData        = tx_data_q;
  assign TxValid       = tx_valid_q;
  assign Busy          = busy;
  assign Done          = (state_q == S_DONE);
  assign Aborted       = aborted_q;
  assign WriteRejected = wr_rej_q;
  assign CharsSent     = chars_q;

endmodule
